// File: rtl/fb_pkg.sv
// Shared types and default widths for the LED frame-buffer write path.
package fb_pkg;

  localparam int FB_ADDR_W = 12;
  localparam int FB_DATA_W = 8;

  typedef enum logic {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_e;

  typedef enum logic {
    GRANT_STREAM = 1'b0,
    GRANT_HOST   = 1'b1
  } fb_grant_e;

endpackage

// File: rtl/fb_rr_arbiter.sv
// Two-way round-robin arbiter between the pixel stream and the host writer.
module fb_rr_arbiter
  import fb_pkg::*;
(
  input  logic clk_in,
  input  logic reset_n,
  input  logic req_stream,
  input  logic req_host,
  input  logic accept,
  output logic gnt_stream,
  output logic gnt_host
);

  fb_grant_e last_grant_q, last_grant_d;

  // On a tie the requester that did not win last time gets the port
  always_comb begin
    gnt_stream   = 1'b0;
    gnt_host     = 1'b0;
    last_grant_d = last_grant_q;
    if (req_stream && req_host) begin
      if (last_grant_q == GRANT_HOST) gnt_stream = 1'b1;
      else                            gnt_host   = 1'b1;
    end else begin
      gnt_stream = req_stream;
      gnt_host   = req_host;
    end
    if (accept) last_grant_d = gnt_stream ? GRANT_STREAM : GRANT_HOST;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) last_grant_q <= GRANT_HOST;
    else          last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/fb_write_ctrl.sv
// Frame-buffer write-port scheduler: stream, host and clear engine share one byte write port.
// Define FB_CLEAR_EN to build the clear engine (CLEAR state and clear pointer).
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int                ADDR_W      = FB_ADDR_W,
  parameter int                DATA_W      = FB_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              stream_valid,
  input  logic [DATA_W-1:0] stream_data,
  input  logic              stream_sof,
  output logic              stream_ready,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              frame_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data
);

  logic [ADDR_W-1:0] stream_ptr_q, stream_ptr_d, stream_addr;
  logic              mem_we_q, mem_we_d, frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              clear_active, clear_start, clear_last;
  logic [ADDR_W-1:0] clear_next;
  logic              allow, gnt_stream, gnt_host;

`ifdef FB_CLEAR_EN
  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;

  assign clear_active = (state_q == FB_CLEAR);
  assign clear_start  = clear_req && !clear_active;
  assign clear_last   = &clear_ptr_q;
  assign clear_next   = clear_ptr_q + 1'b1;

  // clear_ptr tracks the address currently on the write port, so the last cycle of CLEAR issues nothing
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    if (clear_start) begin
      state_d     = FB_CLEAR;
      clear_ptr_d = '0;
    end else if (clear_active) begin
      if (clear_last) begin
        state_d     = FB_IDLE;
        clear_ptr_d = '0;
      end else begin
        clear_ptr_d = clear_next;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FB_IDLE;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
  assign clear_active     = 1'b0;
  assign clear_start      = 1'b0;
  assign clear_last       = 1'b0;
  assign clear_next       = '0;
`endif

  assign allow = reset_n && !clear_active && !clear_start;

  fb_rr_arbiter u_arb (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .req_stream (stream_valid && allow),
    .req_host   (host_valid && allow),
    .accept     (gnt_stream || gnt_host),
    .gnt_stream (gnt_stream),
    .gnt_host   (gnt_host)
  );

  assign stream_ready = gnt_stream;
  assign host_ready   = gnt_host;

  always_comb begin
    stream_addr  = stream_sof ? '0 : stream_ptr_q;
    stream_ptr_d = stream_ptr_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    frame_done_d = 1'b0;
    if (clear_start) begin
      mem_we_d   = 1'b1;
      mem_addr_d = '0;
      mem_data_d = CLEAR_VALUE;
    end else if (clear_active) begin
      if (!clear_last) begin
        mem_we_d   = 1'b1;
        mem_addr_d = clear_next;
        mem_data_d = CLEAR_VALUE;
      end
    end else if (gnt_stream) begin
      mem_we_d     = 1'b1;
      mem_addr_d   = stream_addr;
      mem_data_d   = stream_data;
      frame_done_d = &stream_addr;
      stream_ptr_d = stream_addr + 1'b1;
    end else if (gnt_host) begin
      mem_we_d   = 1'b1;
      mem_addr_d = host_addr;
      mem_data_d = host_data;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      stream_ptr_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      stream_ptr_q <= stream_ptr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign frame_done = frame_done_q;
  assign clear_busy = clear_active;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Self-checking bench for fb_write_ctrl: randomized and directed stimulus against a behavioural model.
// Clear-engine scenarios run when FB_CLEAR_EN is defined; otherwise the disabled behaviour is checked.
module tb_fb_write_ctrl;

  localparam int        AW      = 12;
  localparam int        DW      = 8;
  localparam int        NADDR   = 4096;
  localparam logic [7:0] CLR_VAL = 8'h00;
`ifdef FB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          reset_n = 1'b0;
  logic          stream_valid = 1'b0;
  logic [DW-1:0] stream_data = '0;
  logic          stream_sof = 1'b0;
  logic          stream_ready;
  logic          host_valid = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          host_ready;
  logic          clear_req = 1'b0;
  logic          clear_busy;
  logic          frame_done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  fb_write_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_VALUE(CLR_VAL)) dut (
    .clk_in(clk_in), .reset_n(reset_n),
    .stream_valid(stream_valid), .stream_data(stream_data), .stream_sof(stream_sof),
    .stream_ready(stream_ready),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready),
    .clear_req(clear_req), .clear_busy(clear_busy), .frame_done(frame_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Behavioural model: stream pointer, who won the last tie, and remaining busy cycles of a clear
  int   m_ptr;
  bit   m_last_host;
  int   m_busy_left;
  int   m_clr_addr;
  int   fd_seen = 0;
  int   wr_seen = 0;
  logic obs_sr, obs_hr;

  task automatic model_reset();
    m_ptr       = 0;
    m_last_host = 1'b1;
    m_busy_left = 0;
    m_clr_addr  = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check readies, then check registered outputs
  task automatic drive_cycle(input logic sv, input logic [7:0] sd, input logic sof,
                             input logic hv, input logic [11:0] ha, input logic [7:0] hd,
                             input logic cr);
    logic        e_sr, e_hr, e_we, e_fd, e_busy, busy, cr_eff;
    logic [11:0] e_addr;
    logic [7:0]  e_data;
    int          a;
    stream_valid = sv; stream_data = sd; stream_sof = sof;
    host_valid = hv; host_addr = ha; host_data = hd; clear_req = cr;
    #1;
    busy   = (m_busy_left > 0);
    cr_eff = CLR_EN && cr && !busy;
    e_sr = 1'b0; e_hr = 1'b0;
    if (!busy && !cr_eff) begin
      if (sv && hv) begin
        e_sr = m_last_host;
        e_hr = !m_last_host;
      end else begin
        e_sr = sv;
        e_hr = hv;
      end
    end
    total++;
    if (stream_ready !== e_sr) begin
      bad++;
      $display("[TB] FAIL stream_ready t=%0t got=%b want=%b", $time, stream_ready, e_sr);
    end
    total++;
    if (host_ready !== e_hr) begin
      bad++;
      $display("[TB] FAIL host_ready t=%0t got=%b want=%b", $time, host_ready, e_hr);
    end
    obs_sr = stream_ready;
    obs_hr = host_ready;

    e_we = 1'b0; e_fd = 1'b0; e_addr = '0; e_data = '0;
    if (cr_eff) begin
      e_we = 1'b1; e_addr = '0; e_data = CLR_VAL;
      m_busy_left = NADDR;
      m_clr_addr  = 0;
    end else if (busy) begin
      m_busy_left--;
      if (m_busy_left > 0) begin
        m_clr_addr++;
        e_we = 1'b1; e_addr = m_clr_addr[11:0]; e_data = CLR_VAL;
      end
    end else if (e_sr) begin
      a = sof ? 0 : m_ptr;
      e_we = 1'b1; e_addr = a[11:0]; e_data = sd;
      e_fd = (a == NADDR - 1);
      m_ptr = (a + 1) % NADDR;
      m_last_host = 1'b0;
    end else if (e_hr) begin
      e_we = 1'b1; e_addr = ha; e_data = hd;
      m_last_host = 1'b1;
    end
    e_busy = (m_busy_left > 0);

    @(posedge clk_in);
    #1;
    total++;
    if (mem_we !== e_we) begin
      bad++;
      $display("[TB] FAIL mem_we t=%0t got=%b want=%b", $time, mem_we, e_we);
    end
    if (e_we) begin
      total++;
      if (mem_addr !== e_addr) begin
        bad++;
        $display("[TB] FAIL mem_addr t=%0t got=%0d want=%0d", $time, mem_addr, e_addr);
      end
      total++;
      if (mem_data !== e_data) begin
        bad++;
        $display("[TB] FAIL mem_data t=%0t got=%h want=%h", $time, mem_data, e_data);
      end
    end
    total++;
    if (frame_done !== e_fd) begin
      bad++;
      $display("[TB] FAIL frame_done t=%0t got=%b want=%b", $time, frame_done, e_fd);
    end
    total++;
    if (clear_busy !== e_busy) begin
      bad++;
      $display("[TB] FAIL clear_busy t=%0t got=%b want=%b", $time, clear_busy, e_busy);
    end
    if (mem_we === 1'b1) wr_seen++;
    if (frame_done === 1'b1) fd_seen++;
    @(negedge clk_in);
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    reset_n = 1'b0;
    stream_valid = 1'b0; host_valid = 1'b0; clear_req = 1'b0; stream_sof = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    reset_n = 1'b0;
    stream_valid = 1'b1; host_valid = 1'b1; clear_req = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    total++;
    if ({mem_we, mem_addr, mem_data, frame_done, clear_busy} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs we=%b addr=%0d data=%h fd=%b busy=%b want all 0",
               mem_we, mem_addr, mem_data, frame_done, clear_busy);
    end
    total++;
    if ({stream_ready, host_ready} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_readies got=%b%b want=00", stream_ready, host_ready);
    end
    stream_valid = 1'b0; host_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
    @(negedge clk_in);
  endtask

  task automatic test_stream_frame();
    int fd0;
    apply_reset();
    fd0 = fd_seen;
    for (int i = 0; i < NADDR; i++) drive_cycle(1'b1, i[7:0], (i == 0), 1'b0, '0, '0, 1'b0);
    total++;
    if (fd_seen - fd0 != 1) begin
      bad++;
      $display("[TB] FAIL frame_done_count got=%0d want=1", fd_seen - fd0);
    end
    drive_cycle(1'b1, 8'h3C, 1'b0, 1'b0, '0, '0, 1'b0);
    total++;
    if (mem_addr !== 12'd0) begin
      bad++;
      $display("[TB] FAIL stream_wrap got=%0d want=0", mem_addr);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 8'h10 + i[7:0], 1'b0, 1'b1, 12'h800, 8'hA0 + i[7:0], 1'b0);
      total++;
      if (obs_sr !== ((i % 2) == 0)) begin
        bad++;
        $display("[TB] FAIL rr_order cycle=%0d got_stream=%b want=%b", i, obs_sr, ((i % 2) == 0));
      end
    end
  endtask

  task automatic test_sof_midframe();
    int fd0;
    apply_reset();
    for (int i = 0; i < 37; i++) drive_cycle(1'b1, i[7:0], (i == 0), 1'b0, '0, '0, 1'b0);
    fd0 = fd_seen;
    drive_cycle(1'b1, 8'hE1, 1'b1, 1'b0, '0, '0, 1'b0);
    total++;
    if (mem_addr !== 12'd0) begin
      bad++;
      $display("[TB] FAIL sof_restart got=%0d want=0", mem_addr);
    end
    drive_cycle(1'b1, 8'hE2, 1'b0, 1'b0, '0, '0, 1'b0);
    total++;
    if (mem_addr !== 12'd1) begin
      bad++;
      $display("[TB] FAIL sof_next got=%0d want=1", mem_addr);
    end
    total++;
    if (fd_seen != fd0) begin
      bad++;
      $display("[TB] FAIL sof_no_frame_done got=%0d want=0", fd_seen - fd0);
    end
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    int wr0;
    apply_reset();
    wr0 = wr_seen;
    drive_cycle(1'b1, 8'h11, 1'b0, 1'b1, 12'h055, 8'h22, 1'b1);
    total++;
    if ({obs_sr, obs_hr} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL clear_wins got=%b%b want=00", obs_sr, obs_hr);
    end
    for (int j = 0; j < NADDR; j++)
      drive_cycle(1'b1, j[7:0], 1'b0, 1'b1, 12'h055, 8'h22, ((j % 700) == 5));
    total++;
    if (wr_seen - wr0 != NADDR) begin
      bad++;
      $display("[TB] FAIL clear_write_count got=%0d want=%0d", wr_seen - wr0, NADDR);
    end
    drive_cycle(1'b1, 8'h33, 1'b0, 1'b1, 12'h055, 8'h44, 1'b0);
    total++;
    if ((obs_sr | obs_hr) !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clear_resume got=%b%b want one grant", obs_sr, obs_hr);
    end
  endtask

  task automatic test_reset_mid_clear();
    apply_reset();
    drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    for (int j = 0; j < 100; j++) drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    reset_n = 1'b0;
    stream_valid = 1'b1;
    #1;
    total++;
    if ({mem_we, mem_addr, mem_data, frame_done, clear_busy, stream_ready, host_ready} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_mid_clear we=%b addr=%0d data=%h fd=%b busy=%b sr=%b hr=%b want all 0",
               mem_we, mem_addr, mem_data, frame_done, clear_busy, stream_ready, host_ready);
    end
    @(negedge clk_in);
    reset_n = 1'b1;
    model_reset();
    drive_cycle(1'b1, 8'h5A, 1'b0, 1'b0, '0, '0, 1'b0);
    total++;
    if (mem_addr !== 12'd0) begin
      bad++;
      $display("[TB] FAIL after_reset_addr got=%0d want=0", mem_addr);
    end
  endtask
`else
  task automatic test_clear_disabled();
    apply_reset();
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 12'h123, 8'h77, 1'b1);
    total++;
    if (obs_hr !== 1'b1) begin
      bad++;
      $display("[TB] FAIL host_with_clear got=%b want=1", obs_hr);
    end
    total++;
    if (mem_addr !== 12'h123 || mem_data !== 8'h77) begin
      bad++;
      $display("[TB] FAIL host_write got=%h/%h want=123/77", mem_addr, mem_data);
    end
    for (int j = 0; j < 4; j++) drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask
`endif

  task automatic test_random();
    logic sv, hv, sof, cr;
    apply_reset();
    for (int j = 0; j < 3000; j++) begin
      sv  = ($urandom_range(0, 3) != 0);
      hv  = ($urandom_range(0, 2) == 0);
      sof = ($urandom_range(0, 63) == 0);
      cr  = CLR_EN ? ($urandom_range(0, 799) == 0) : ($urandom_range(0, 49) == 0);
      drive_cycle(sv, 8'($urandom), sof, hv, 12'($urandom), 8'($urandom), cr);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_stream_frame();
    test_round_robin();
    test_sof_midframe();
`ifdef FB_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_clear_disabled();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
